// File: rtl/axi_w_slave_sink.sv
// AXI write-path slave sink: takes one AW request, drains packed W beats into a
// byte-enabled single-port SRAM with zero latency, then returns a B response.
module axi_w_slave_sink #(
    parameter int ID_W   = 8,
    parameter int ADDR_W = 32,
    parameter int MEM_AW = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W-1:0]   awid,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic              awvalid,
    output logic              awready,
    input  logic [36:0]       wpkt,
    input  logic              wvalid,
    output logic              wready,
    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    output logic              mem_cs,
    output logic [3:0]        mem_we,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_di
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        len_q, len_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              incr_q, incr_d;
    logic              err_q, err_d;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        last_beat;

    assign wdata     = wpkt[36:5];
    assign wstrb     = wpkt[4:1];
    assign wlast     = wpkt[0];
    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            incr_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            incr_q  <= incr_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        incr_d   = incr_q;
        err_d    = err_q;
        awready  = 1'b0;
        wready   = 1'b0;
        bvalid   = 1'b0;
        bid      = '0;
        bresp    = 2'b00;
        mem_cs   = 1'b0;
        mem_we   = 4'h0;
        mem_addr = '0;
        mem_di   = '0;

        case (state_q)
            S_IDLE: begin
                awready = 1'b1;
                if (awvalid) begin
                    id_d    = awid;
                    addr_d  = awaddr;
                    len_d   = awlen;
                    incr_d  = (awburst == 2'b01);
                    err_d   = (awsize != 3'b010) || awburst[1] || (awaddr[1:0] != 2'b00);
                    cnt_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                wready = 1'b1;
                if (wvalid) begin
                    mem_cs   = 1'b1;
                    mem_we   = err_q ? 4'h0 : wstrb;
                    mem_addr = addr_q[MEM_AW+1:2];
                    mem_di   = wdata;
                    if (incr_q) begin
                        addr_d = addr_q + ADDR_W'(4);
                    end
                    // A WLAST that disagrees with the beat count poisons the response
                    if (wlast != last_beat) begin
                        err_d = 1'b1;
                    end
                    if (wlast || last_beat) begin
                        state_d = S_RESP;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_RESP: begin
                bvalid = 1'b1;
                bid    = id_q;
                bresp  = err_q ? 2'b10 : 2'b00;
                if (bready) begin
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_w_slave_sink.sv
// Bench for axi_w_slave_sink: directed scenarios plus randomized bursts checked
// against a burst-level model of expected writes and response.
module tb_axi_w_slave_sink;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int MEM_AW = 14;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [3:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awvalid;
    logic              awready;
    logic [36:0]       wpkt;
    logic              wvalid;
    logic              wready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic              mem_cs;
    logic [3:0]        mem_we;
    logic [MEM_AW-1:0] mem_addr;
    logic [31:0]       mem_di;

    int checks = 0;
    int errors = 0;

    logic [31:0] bd [18];
    logic [3:0]  bs [18];
    logic        bl [18];

    always #5 clk = ~clk;

    axi_w_slave_sink #(.ID_W(ID_W), .ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wpkt(wpkt), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_awready"}, awready, 1);
        chk({tag, "_wready"}, wready, 0);
        chk({tag, "_bvalid"}, bvalid, 0);
        chk({tag, "_bid"}, bid, 0);
        chk({tag, "_bresp"}, bresp, 0);
        chk({tag, "_mem_cs"}, mem_cs, 0);
        chk({tag, "_mem_we"}, mem_we, 0);
        chk({tag, "_mem_addr"}, mem_addr, 0);
        chk({tag, "_mem_di"}, mem_di, 0);
    endtask

    // gap_mode: 0 = wvalid always high, 1 = toggles 1/0, 2 = random.
    // rst_after >= 0 pulls reset once that many beats have been accepted.
    task automatic run_burst(input string name, input logic [7:0] id, input logic [31:0] addr,
                             input logic [3:0] len, input logic [2:0] size, input logic [1:0] burst,
                             input int nsend, input int gap_mode, input int bdelay, input int rst_after);
        int          consumed;
        int          idx;
        int          cyc;
        logic        aw_err;
        logic        exp_err;
        logic        tog;
        logic        wv;
        logic [31:0] a;
        logic [1:0]  exp_resp;

        // Model: the burst ends at the first beat carrying WLAST or the (len+1)-th beat
        consumed = nsend;
        for (int i = 0; i < nsend; i++) begin
            if (bl[i] || i == int'(len)) begin
                consumed = i + 1;
                break;
            end
        end
        aw_err   = (size != 3'b010) || burst[1] || (addr[1:0] != 2'b00);
        exp_err  = aw_err || (bl[consumed-1] != ((consumed - 1) == int'(len)));
        exp_resp = exp_err ? 2'b10 : 2'b00;

        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        wvalid = 1'b0;
        #1;
        chk("aw_ready_idle", awready, 1);
        chk("w_ready_idle", wready, 0);
        @(posedge clk);

        idx = 0;
        cyc = 0;
        tog = 1'b1;
        while (idx < consumed && cyc < 200) begin
            @(negedge clk);
            awvalid = (gap_mode == 1);
            awid    = ~id;
            wv = (gap_mode == 0) ? 1'b1 : (gap_mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = ~tog;
            wvalid = wv;
            wpkt   = {bd[idx], bs[idx], bl[idx]};
            #1;
            chk("data_wready", wready, 1);
            chk("data_awready", awready, 0);
            chk("data_bvalid", bvalid, 0);
            if (wv) begin
                a = addr + ((burst == 2'b01) ? 32'(4 * idx) : 32'd0);
                chk("beat_cs", mem_cs, 1);
                chk("beat_we", mem_we, aw_err ? 4'h0 : bs[idx]);
                if (!burst[1]) chk("beat_addr", mem_addr, a[MEM_AW+1:2]);
                chk("beat_di", mem_di, bd[idx]);
            end else begin
                chk("idle_cs", mem_cs, 0);
                chk("idle_we", mem_we, 0);
            end
            @(posedge clk);
            if (wv) idx++;
            cyc++;
            if (rst_after >= 0 && idx == rst_after) begin
                #2;
                rst_n  = 1'b0;
                wvalid = 1'b1;
                #1;
                chk_reset_outputs("midburst_reset");
                @(negedge clk);
                wvalid  = 1'b0;
                awvalid = 1'b0;
                @(posedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                $display("burst %s: reset after %0d beats", name, idx);
                return;
            end
        end
        if (idx < consumed) chk("beat_timeout", idx, consumed);

        // Response phase: offer a stray beat and a pending AW, neither may be taken
        for (int k = 0; k <= bdelay; k++) begin
            @(negedge clk);
            wvalid  = (nsend > consumed);
            wpkt    = {bd[consumed], bs[consumed], bl[consumed]};
            awvalid = 1'b1;
            awid    = ~id;
            bready  = (k == bdelay);
            #1;
            chk("resp_wready", wready, 0);
            chk("resp_mem_cs", mem_cs, 0);
            chk("resp_awready", awready, 0);
            chk("resp_bvalid", bvalid, 1);
            chk("resp_bid", bid, id);
            chk("resp_bresp", bresp, exp_resp);
            @(posedge clk);
        end
        @(negedge clk);
        bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        #1;
        chk("post_bvalid", bvalid, 0);
        chk("post_awready", awready, 1);
        $display("burst %s: id=%0h addr=%08h len=%0d burst=%0d beats=%0d bresp=%0d bid=%0h",
                 name, id, addr, len, burst, consumed, exp_resp, bid);
    endtask

    task automatic fill_beats(input int n, input int last_at);
        for (int i = 0; i < 18; i++) begin
            bd[i] = $urandom;
            bs[i] = 4'($urandom_range(0, 15));
            bl[i] = (i == last_at);
        end
        if (n < 0) bd[0] = bd[0];
    endtask

    initial begin
        int          r;
        int          p;
        int          ln;
        int          ns;
        logic [1:0]  bu;
        logic [2:0]  sz;
        logic [31:0] ad;

        rst_n = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wpkt = '0; wvalid = 1'b0; bready = 1'b0;
        #1;
        chk_reset_outputs("por");
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: INCR 4 beats
        fill_beats(4, 3);
        for (int i = 0; i < 4; i++) begin bd[i] = 32'(i + 1); bs[i] = 4'hF; end
        run_burst("T1", 8'h5A, 32'h100, 4'd3, 3'b010, 2'b01, 4, 0, 0, -1);

        // T2: FIXED 2 beats, strobes 3 then C
        fill_beats(2, 1);
        bs[0] = 4'h3; bs[1] = 4'hC;
        run_burst("T2", 8'h11, 32'h20, 4'd1, 3'b010, 2'b00, 2, 0, 0, -1);

        // T3: early WLAST, then missing WLAST
        fill_beats(4, 1);
        run_burst("T3a", 8'h33, 32'h400, 4'd3, 3'b010, 2'b01, 4, 0, 1, -1);
        fill_beats(3, -1);
        run_burst("T3b", 8'h34, 32'h800, 4'd1, 3'b010, 2'b01, 3, 0, 0, -1);

        // T4: WRAP unsupported
        fill_beats(2, 1);
        bs[0] = 4'hF; bs[1] = 4'h5;
        run_burst("T4", 8'h44, 32'h40, 4'd1, 3'b010, 2'b10, 2, 0, 0, -1);

        // T5: toggling wvalid and slow bready
        fill_beats(4, 3);
        run_burst("T5", 8'h55, 32'h1000, 4'd3, 3'b010, 2'b01, 4, 1, 5, -1);

        // T6: reset mid-burst, then a clean burst
        fill_beats(4, 3);
        run_burst("T6a", 8'h66, 32'h2000, 4'd3, 3'b010, 2'b01, 4, 0, 0, 1);
        fill_beats(4, 3);
        run_burst("T6b", 8'h67, 32'h2000, 4'd3, 3'b010, 2'b01, 4, 0, 0, -1);

        // Address wrap past the top of the byte address space
        fill_beats(4, 3);
        run_burst("wrap", 8'h77, 32'hFFFF_FFF8, 4'd3, 3'b010, 2'b01, 4, 2, 0, -1);

        for (int n = 0; n < 40; n++) begin
            ln = $urandom_range(0, 15);
            r  = $urandom_range(0, 9);
            bu = (r < 4) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            ad = {$urandom} & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) ad = ad | 32'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) ad = 32'hFFFF_FFF0;
            p = $urandom_range(0, 5);
            if (p == 4 && ln > 0) begin
                fill_beats(ln + 1, $urandom_range(0, ln - 1));
                ns = ln + 1;
            end else if (p == 5) begin
                fill_beats(ln + 2, -1);
                ns = ln + 2;
            end else begin
                fill_beats(ln + 1, ln);
                ns = ln + 1 + $urandom_range(0, 1);
            end
            run_burst($sformatf("R%0d", n), 8'($urandom_range(0, 255)), ad, 4'(ln), sz, bu,
                      ns, $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
